// File: rtl/fifo_pkg.sv
// fifo_pkg: shared parameter checks and width helpers for the level-tracking FIFO.
package fifo_pkg;

    function automatic bit params_ok(input int depth_x, input int af_level, input int ae_level);
        return depth_x >= 1 && af_level >= 1 && af_level <= (1 << depth_x)
            && ae_level >= 0 && ae_level < (1 << depth_x);
    endfunction

    function automatic int level_w(input int depth_x);
        return depth_x + 1;
    endfunction

endpackage

// File: rtl/fifo_ptr.sv
// fifo_ptr: wrap-bit pointer register with clock enable, flush-to-zero and increment.
module fifo_ptr #(
    parameter int W = 2
) (
    input  logic         clk_i,
    input  logic         resetb_i,
    input  logic         clk_en_i,
    input  logic         flush_i,
    input  logic         inc_i,
    output logic [W-1:0] ptr_o
);

    logic [W-1:0] ptr_q, ptr_d;

    always_comb ptr_d = flush_i ? '0 : ptr_q + W'(inc_i);

    always_ff @(posedge clk_i or negedge resetb_i)
        if (!resetb_i)     ptr_q <= '0;
        else if (clk_en_i) ptr_q <= ptr_d;

    assign ptr_o = ptr_q;

endmodule

// File: rtl/fifo_lvl.sv
// fifo_lvl: synchronous FWFT FIFO with occupancy level, watermarks and sticky error flags.
module fifo_lvl
    import fifo_pkg::*;
#(
    parameter int C_FIFO_WIDTH   = 1,
    parameter int C_FIFO_DEPTH_X = 1,
    parameter int C_AF_LEVEL     = (2 ** C_FIFO_DEPTH_X) - 1,
    parameter int C_AE_LEVEL     = 1,
    parameter int C_FIFO_DEPTH   = 2 ** C_FIFO_DEPTH_X
) (
    input  logic                      clk_i,
    input  logic                      resetb_i,
    input  logic                      clk_en_i,
    input  logic                      flush_i,
    input  logic                      clr_err_i,
    output logic                      empty_o,
    output logic                      full_o,
    output logic                      almost_empty_o,
    output logic                      almost_full_o,
    output logic [C_FIFO_DEPTH_X:0]   level_o,
    output logic                      overflow_o,
    output logic                      underflow_o,
    input  logic                      wr_i,
    input  logic [C_FIFO_WIDTH-1:0]   din_i,
    input  logic                      rd_i,
    output logic [C_FIFO_WIDTH-1:0]   dout_o
);

    localparam int LW = level_w(C_FIFO_DEPTH_X);

    if (!params_ok(C_FIFO_DEPTH_X, C_AF_LEVEL, C_AE_LEVEL)) begin : g_param_err
        $fatal(1, "fifo_lvl: parameter out of range");
    end

    logic [C_FIFO_WIDTH-1:0] mem [C_FIFO_DEPTH];
    logic [LW-1:0]           wr_ptr, rd_ptr;
    logic                    pop_acc, push_acc;
    logic                    ovf_q, ovf_d, unf_q, unf_d;

    assign level_o        = wr_ptr - rd_ptr;
    assign empty_o        = level_o == '0;
    assign full_o         = level_o == LW'(C_FIFO_DEPTH);
    assign almost_empty_o = level_o <= LW'(C_AE_LEVEL);
    assign almost_full_o  = level_o >= LW'(C_AF_LEVEL);
    assign overflow_o     = ovf_q;
    assign underflow_o    = unf_q;
    assign dout_o         = mem[rd_ptr[C_FIFO_DEPTH_X-1:0]];

    // A pop frees the head slot this cycle, so a push while full still lands.
    assign pop_acc  = rd_i & ~empty_o & ~flush_i;
    assign push_acc = wr_i & (~full_o | pop_acc) & ~flush_i;

    fifo_ptr #(.W(LW)) u_wr_ptr (
        .clk_i(clk_i), .resetb_i(resetb_i), .clk_en_i(clk_en_i),
        .flush_i(flush_i), .inc_i(push_acc), .ptr_o(wr_ptr)
    );

    fifo_ptr #(.W(LW)) u_rd_ptr (
        .clk_i(clk_i), .resetb_i(resetb_i), .clk_en_i(clk_en_i),
        .flush_i(flush_i), .inc_i(pop_acc), .ptr_o(rd_ptr)
    );

    always_ff @(posedge clk_i)
        if (clk_en_i && push_acc) mem[wr_ptr[C_FIFO_DEPTH_X-1:0]] <= din_i;

    always_comb begin
        ovf_d = flush_i ? 1'b0 : (wr_i & ~push_acc) ? 1'b1 : clr_err_i ? 1'b0 : ovf_q;
        unf_d = flush_i ? 1'b0 : (rd_i & empty_o)   ? 1'b1 : clr_err_i ? 1'b0 : unf_q;
    end

    always_ff @(posedge clk_i or negedge resetb_i)
        if (!resetb_i) begin
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else if (clk_en_i) begin
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end

endmodule

// File: tb/tb_fifo_lvl.sv
// tb_fifo_lvl: directed checks of the level FIFO at depth 4, AF=3, AE=1, width 8.
module tb_fifo_lvl;

    logic       clk_i = 1'b0;
    logic       resetb_i, clk_en_i, flush_i, clr_err_i, wr_i, rd_i;
    logic [7:0] din_i, dout_o;
    logic       empty_o, full_o, almost_empty_o, almost_full_o, overflow_o, underflow_o;
    logic [2:0] level_o;
    int         n_tests = 0;
    int         n_fail  = 0;

    fifo_lvl #(
        .C_FIFO_WIDTH(8), .C_FIFO_DEPTH_X(2), .C_AF_LEVEL(3), .C_AE_LEVEL(1)
    ) dut (
        .clk_i(clk_i), .resetb_i(resetb_i), .clk_en_i(clk_en_i), .flush_i(flush_i),
        .clr_err_i(clr_err_i), .empty_o(empty_o), .full_o(full_o),
        .almost_empty_o(almost_empty_o), .almost_full_o(almost_full_o),
        .level_o(level_o), .overflow_o(overflow_o), .underflow_o(underflow_o),
        .wr_i(wr_i), .din_i(din_i), .rd_i(rd_i), .dout_o(dout_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cycle(input logic wr, input logic [7:0] d, input logic rd,
                         input logic fl = 1'b0, input logic clr = 1'b0, input logic en = 1'b1);
        wr_i = wr; din_i = d; rd_i = rd; flush_i = fl; clr_err_i = clr; clk_en_i = en;
        @(posedge clk_i);
        #1;
        wr_i = 1'b0; rd_i = 1'b0; flush_i = 1'b0; clr_err_i = 1'b0; clk_en_i = 1'b1;
    endtask

    task automatic push(input logic [7:0] d);
        cycle(1'b1, d, 1'b0);
    endtask

    task automatic pop_chk(input string tag, input logic [7:0] exp);
        check(tag, dout_o, exp);
        cycle(1'b0, 8'h00, 1'b1);
    endtask

    initial begin
        resetb_i = 1'b0; clk_en_i = 1'b1; flush_i = 1'b0; clr_err_i = 1'b0;
        wr_i = 1'b0; rd_i = 1'b0; din_i = 8'h00;
        #12;
        check("rst_empty", empty_o, 1);
        check("rst_full", full_o, 0);
        check("rst_level", level_o, 0);
        check("rst_ae", almost_empty_o, 1);
        check("rst_af", almost_full_o, 0);
        check("rst_ovf", overflow_o, 0);
        check("rst_unf", underflow_o, 0);
        resetb_i = 1'b1;

        push(8'h11); check("t1_lvl1", level_o, 1); check("t1_ae1", almost_empty_o, 1);
        push(8'h22); check("t1_lvl2", level_o, 2); check("t1_ae2", almost_empty_o, 0);
        check("t1_af2", almost_full_o, 0);
        push(8'h33); check("t1_lvl3", level_o, 3); check("t1_af3", almost_full_o, 1);
        check("t1_full3", full_o, 0);
        push(8'h44); check("t1_lvl4", level_o, 4); check("t1_full4", full_o, 1);
        pop_chk("t1_d0", 8'h11); pop_chk("t1_d1", 8'h22);
        pop_chk("t1_d2", 8'h33); pop_chk("t1_d3", 8'h44);
        check("t1_empty", empty_o, 1);

        for (int k = 1; k <= 4; k++) push(8'(k));
        cycle(1'b1, 8'h55, 1'b0);
        check("t2_ovf", overflow_o, 1);
        check("t2_lvl", level_o, 4);
        cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        check("t2_clr", overflow_o, 0);

        cycle(1'b1, 8'hAA, 1'b1);
        check("t3_lvl", level_o, 4);
        check("t3_ovf", overflow_o, 0);
        pop_chk("t3_d0", 8'h02); pop_chk("t3_d1", 8'h03);
        pop_chk("t3_d2", 8'h04); pop_chk("t3_d3", 8'hAA);
        check("t3_empty", empty_o, 1);

        cycle(1'b0, 8'h00, 1'b1);
        check("t4_unf", underflow_o, 1);
        check("t4_lvl0", level_o, 0);
        cycle(1'b1, 8'h77, 1'b1);
        check("t4_lvl1", level_o, 1);
        check("t4_unf2", underflow_o, 1);
        check("t4_ovf", overflow_o, 0);
        pop_chk("t4_d", 8'h77);
        cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        check("t4_clr", underflow_o, 0);

        for (int i = 0; i < 10; i++) begin
            for (int k = 0; k < 4; k++) push(8'(i * 16 + k));
            check("t5_lvl", level_o, 4);
            for (int k = 0; k < 4; k++) pop_chk("t5_d", 8'(i * 16 + k));
            check("t5_empty", empty_o, 1);
        end

        for (int k = 1; k <= 4; k++) push(8'(8'h20 + k));
        cycle(1'b1, 8'h55, 1'b0);
        pop_chk("t6_d0", 8'h21); pop_chk("t6_d1", 8'h22);
        check("t6_lvl2", level_o, 2);
        check("t6_ovf", overflow_o, 1);
        cycle(1'b1, 8'h99, 1'b0, 1'b1);
        check("t6_flush_lvl", level_o, 0);
        check("t6_flush_ovf", overflow_o, 0);
        check("t6_flush_unf", underflow_o, 0);
        push(8'h5A);
        cycle(1'b1, 8'h66, 1'b0, 1'b0, 1'b0, 1'b0);
        check("t6_en_wr", level_o, 1);
        cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
        check("t6_en_rd", level_o, 1);
        cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
        check("t6_en_fl", level_o, 1);
        check("t6_en_d", dout_o, 8'h5A);
        push(8'h6B);
        check("t6_lvl_pre", level_o, 2);
        #2 resetb_i = 1'b0;
        #1;
        check("t6_rst_empty", empty_o, 1);
        check("t6_rst_lvl", level_o, 0);
        #1 resetb_i = 1'b1;
        push(8'hC3);
        check("t6_post_lvl", level_o, 1);
        check("t6_post_d", dout_o, 8'hC3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
